// File: rtl/rotor_stack_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : rotor_stack_stepper
//  Description : Odometer-style rotor stack stepper with notch turnover and an
//                optional middle-rotor double-step anomaly. Rotor 0 is the
//                fastest rotor.
//
//  Ports       : clock       - rising-edge clock
//                reset       - synchronous, active-high reset
//                step        - keypress level; each rising edge = one step
//                load        - single-cycle pulse loading start_pos
//                start_pos   - packed start positions, rotor i at [i*PW +: PW]
//                notch_pos   - packed turnover positions, sampled live
//                inc         - per-rotor manual +1 pulses (no carry)
//                pos         - registered rotor positions (packed)
//                step_done   - pulses in the cycle pos reflects a step
//                carry_out   - pulses with step_done when the slowest rotor
//                              stepped off its notch
//                step_count  - steps since last reset or load (wraps)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module rotor_stack_stepper #(
    parameter int NUM_ROTORS  = 3,
    parameter int ALPHA       = 26,
    parameter int PW          = 5,
    parameter int DOUBLE_STEP = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     step,
    input  logic                     load,
    input  logic [NUM_ROTORS*PW-1:0] start_pos,
    input  logic [NUM_ROTORS*PW-1:0] notch_pos,
    input  logic [NUM_ROTORS-1:0]    inc,
    output logic [NUM_ROTORS*PW-1:0] pos,
    output logic                     step_done,
    output logic                     carry_out,
    output logic [15:0]              step_count
);

    localparam logic [PW-1:0] c_last_pos = PW'(ALPHA - 1);

    logic                  r_step_q;
    // Cleared while step is high at reset release, so a key held through
    // reset must be released before it can request a step.
    logic                  r_armed;
    logic                  r_step_done;
    logic                  r_carry_out;
    logic [15:0]           r_step_count;
    logic [PW-1:0]         r_pos      [NUM_ROTORS];

    logic [PW-1:0]         w_pos_next [NUM_ROTORS];
    logic [PW-1:0]         w_load_pos [NUM_ROTORS];
    logic [NUM_ROTORS-1:0] w_match;
    logic [NUM_ROTORS-1:0] w_adv;
    logic                  w_step_edge;

    assign w_step_edge = step & ~r_step_q & r_armed;

    generate
        for (genvar i = 0; i < NUM_ROTORS; i++) begin : g_rotor
            logic [PW-1:0] w_notch;
            logic [PW-1:0] w_start;

            assign w_notch = notch_pos[i*PW +: PW];
            assign w_start = start_pos[i*PW +: PW];

            // A notch outside the alphabet never matches.
            assign w_match[i]    = (32'(w_notch) < ALPHA) && (r_pos[i] == w_notch);
            assign w_pos_next[i] = (r_pos[i] == c_last_pos) ? '0 : r_pos[i] + PW'(1);
            assign w_load_pos[i] = (32'(w_start) < ALPHA) ? w_start : '0;
            assign pos[i*PW +: PW] = r_pos[i];

            // All advance decisions use pre-step positions only.
            if (i == 0) begin : g_adv_first
                assign w_adv[i] = 1'b1;
            end else if ((DOUBLE_STEP != 0) && (i <= NUM_ROTORS - 2)) begin : g_adv_double
                // Middle rotors also kick themselves forward off their own
                // notch (the double-step anomaly).
                assign w_adv[i] = w_match[i-1] | w_match[i];
            end else begin : g_adv_single
                assign w_adv[i] = w_match[i-1];
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_step_q     <= 1'b0;
            r_armed      <= ~step;
            r_step_done  <= 1'b0;
            r_carry_out  <= 1'b0;
            r_step_count <= '0;
            for (int i = 0; i < NUM_ROTORS; i++) begin
                r_pos[i] <= '0;
            end
        end else begin
            r_step_q    <= step;
            r_step_done <= 1'b0;
            r_carry_out <= 1'b0;
            if (!step) begin
                r_armed <= 1'b1;
            end

            // Priority load > step > inc; losers are dropped, not queued.
            if (load) begin
                r_step_count <= '0;
                for (int i = 0; i < NUM_ROTORS; i++) begin
                    r_pos[i] <= w_load_pos[i];
                end
            end else if (w_step_edge) begin
                r_step_done  <= 1'b1;
                r_carry_out  <= w_adv[NUM_ROTORS-1] & w_match[NUM_ROTORS-1];
                r_step_count <= r_step_count + 16'd1;
                for (int i = 0; i < NUM_ROTORS; i++) begin
                    if (w_adv[i]) begin
                        r_pos[i] <= w_pos_next[i];
                    end
                end
            end else begin
                for (int i = 0; i < NUM_ROTORS; i++) begin
                    if (inc[i]) begin
                        r_pos[i] <= w_pos_next[i];
                    end
                end
            end
        end
    end

    assign step_done  = r_step_done;
    assign carry_out  = r_carry_out;
    assign step_count = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_rotor_stack_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rotor_stack_stepper
//  Description : Directed self-checking bench for rotor_stack_stepper with
//                default parameters (3 rotors, ALPHA=26, PW=5, double-step).
//                Packed vectors are written {rotor2, rotor1, rotor0}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rotor_stack_stepper;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        step  = 1'b0;
    logic        load  = 1'b0;
    logic [14:0] start_pos = '0;
    logic [14:0] notch_pos = '0;
    logic [2:0]  inc = '0;
    logic [14:0] pos;
    logic        step_done;
    logic        carry_out;
    logic [15:0] step_count;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [4:0] c_nn = 5'd31;   // notch value that never matches

    rotor_stack_stepper dut (
        .clock      (clock),
        .reset      (reset),
        .step       (step),
        .load       (load),
        .start_pos  (start_pos),
        .notch_pos  (notch_pos),
        .inc        (inc),
        .pos        (pos),
        .step_done  (step_done),
        .carry_out  (carry_out),
        .step_count (step_count)
    );

    always #5 clock = ~clock;

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [14:0] sp);
        start_pos = sp;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_vec++;
        if (pos !== 15'd0) begin
            $display("FAIL reset_pos got=%h exp=%h", pos, 15'd0); n_err++;
        end
        n_vec++;
        if ({step_done, carry_out, step_count} !== 18'd0) begin
            $display("FAIL reset_flags got done=%b carry=%b cnt=%0d exp 0/0/0",
                     step_done, carry_out, step_count); n_err++;
        end
    endtask

    task automatic test_basic_step();
        notch_pos = {c_nn, c_nn, 5'd25};
        do_load({5'd0, 5'd0, 5'd24});
        n_vec++;
        if (pos !== {5'd0, 5'd0, 5'd24} || step_done !== 1'b0) begin
            $display("FAIL basic_load got pos=%h done=%b exp pos=%h done=0",
                     pos, step_done, {5'd0, 5'd0, 5'd24}); n_err++;
        end
        step = 1'b1; tick();
        n_vec++;
        if (pos !== {5'd0, 5'd0, 5'd25} || step_done !== 1'b1 || step_count !== 16'd1) begin
            $display("FAIL basic_step1 got pos=%h done=%b cnt=%0d exp pos=%h done=1 cnt=1",
                     pos, step_done, step_count, {5'd0, 5'd0, 5'd25}); n_err++;
        end
        step = 1'b0; tick();
        n_vec++;
        if (step_done !== 1'b0) begin
            $display("FAIL basic_done_pulse got=%b exp=0", step_done); n_err++;
        end
        step = 1'b1; tick();
        n_vec++;
        if (pos !== {5'd0, 5'd1, 5'd0} || step_done !== 1'b1 || step_count !== 16'd2 ||
            carry_out !== 1'b0) begin
            $display("FAIL basic_step2 got pos=%h done=%b cnt=%0d carry=%b exp pos=%h 1 2 0",
                     pos, step_done, step_count, carry_out, {5'd0, 5'd1, 5'd0}); n_err++;
        end
        step = 1'b0; tick();
    endtask

    task automatic test_double_step();
        notch_pos = {c_nn, 5'd4, 5'd16};
        do_load({5'd0, 5'd3, 5'd16});
        step = 1'b1; tick();
        n_vec++;
        if (pos !== {5'd0, 5'd4, 5'd17}) begin
            $display("FAIL dstep_1 got=%h exp=%h", pos, {5'd0, 5'd4, 5'd17}); n_err++;
        end
        step = 1'b0; tick();
        step = 1'b1; tick();
        n_vec++;
        if (pos !== {5'd1, 5'd5, 5'd18} || step_count !== 16'd2 || carry_out !== 1'b0) begin
            $display("FAIL dstep_2 got pos=%h cnt=%0d carry=%b exp pos=%h cnt=2 carry=0",
                     pos, step_count, carry_out, {5'd1, 5'd5, 5'd18}); n_err++;
        end
        step = 1'b0; tick();
    endtask

    task automatic test_wrap_carry();
        notch_pos = {5'd25, 5'd25, 5'd25};
        do_load({5'd25, 5'd25, 5'd25});
        step = 1'b1; tick();
        n_vec++;
        if (pos !== 15'd0 || carry_out !== 1'b1 || step_done !== 1'b1 || step_count !== 16'd1) begin
            $display("FAIL wrap_carry got pos=%h carry=%b done=%b cnt=%0d exp pos=0 1 1 1",
                     pos, carry_out, step_done, step_count); n_err++;
        end
        step = 1'b0; tick();
        n_vec++;
        if (carry_out !== 1'b0) begin
            $display("FAIL carry_pulse got=%b exp=0", carry_out); n_err++;
        end
    endtask

    task automatic test_priority_load();
        notch_pos = {c_nn, c_nn, c_nn};
        do_load({5'd1, 5'd2, 5'd3});
        step = 1'b1; tick();
        step = 1'b0; tick();
        // Load and a step rising edge together: load wins, step is dropped.
        start_pos = {5'd7, 5'd8, 5'd9};
        load = 1'b1; step = 1'b1;
        tick();
        load = 1'b0;
        n_vec++;
        if (pos !== {5'd7, 5'd8, 5'd9} || step_count !== 16'd0 || step_done !== 1'b0) begin
            $display("FAIL prio_load got pos=%h cnt=%0d done=%b exp pos=%h cnt=0 done=0",
                     pos, step_count, step_done, {5'd7, 5'd8, 5'd9}); n_err++;
        end
        tick(); tick();
        n_vec++;
        if (pos !== {5'd7, 5'd8, 5'd9} || step_done !== 1'b0 || step_count !== 16'd0) begin
            $display("FAIL prio_held got pos=%h done=%b cnt=%0d exp pos=%h done=0 cnt=0",
                     pos, step_done, step_count, {5'd7, 5'd8, 5'd9}); n_err++;
        end
        step = 1'b0; tick();
    endtask

    task automatic test_inc();
        notch_pos = {c_nn, c_nn, c_nn};
        do_load({5'd5, 5'd25, 5'd3});
        inc = 3'b010; tick(); inc = 3'b000;
        n_vec++;
        if (pos !== {5'd5, 5'd0, 5'd3} || step_done !== 1'b0 || step_count !== 16'd0) begin
            $display("FAIL inc_wrap got pos=%h done=%b cnt=%0d exp pos=%h done=0 cnt=0",
                     pos, step_done, step_count, {5'd5, 5'd0, 5'd3}); n_err++;
        end
        inc = 3'b101; tick(); inc = 3'b000;
        n_vec++;
        if (pos !== {5'd6, 5'd0, 5'd4}) begin
            $display("FAIL inc_multi got=%h exp=%h", pos, {5'd6, 5'd0, 5'd4}); n_err++;
        end
        // Step edge and inc together: step wins, inc is discarded.
        inc = 3'b010; step = 1'b1; tick(); inc = 3'b000;
        n_vec++;
        if (pos !== {5'd6, 5'd0, 5'd5} || step_count !== 16'd1 || step_done !== 1'b1) begin
            $display("FAIL inc_vs_step got pos=%h cnt=%0d done=%b exp pos=%h cnt=1 done=1",
                     pos, step_count, step_done, {5'd6, 5'd0, 5'd5}); n_err++;
        end
        step = 1'b0; tick();
    endtask

    task automatic test_load_invalid();
        do_load({5'd1, 5'd30, 5'd2});
        n_vec++;
        if (pos !== {5'd1, 5'd0, 5'd2}) begin
            $display("FAIL load_30 got=%h exp=%h", pos, {5'd1, 5'd0, 5'd2}); n_err++;
        end
        do_load({5'd26, 5'd25, 5'd0});
        n_vec++;
        if (pos !== {5'd0, 5'd25, 5'd0}) begin
            $display("FAIL load_26 got=%h exp=%h", pos, {5'd0, 5'd25, 5'd0}); n_err++;
        end
    endtask

    task automatic test_reset_mid();
        notch_pos = {c_nn, c_nn, c_nn};
        do_load({5'd3, 5'd4, 5'd5});
        step = 1'b1; tick();
        step = 1'b0; tick();
        reset = 1'b1; step = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (pos !== 15'd0 || step_done !== 1'b0 || step_count !== 16'd0) begin
            $display("FAIL reset_mid got pos=%h done=%b cnt=%0d exp 0/0/0",
                     pos, step_done, step_count); n_err++;
        end
        // Step still held after release: no step may occur.
        tick(); tick();
        n_vec++;
        if (pos !== 15'd0 || step_done !== 1'b0 || step_count !== 16'd0) begin
            $display("FAIL reset_held got pos=%h done=%b cnt=%0d exp 0/0/0",
                     pos, step_done, step_count); n_err++;
        end
        step = 1'b0; tick();
        step = 1'b1; tick();
        n_vec++;
        if (pos !== {5'd0, 5'd0, 5'd1} || step_done !== 1'b1 || step_count !== 16'd1) begin
            $display("FAIL reset_rearm got pos=%h done=%b cnt=%0d exp pos=%h done=1 cnt=1",
                     pos, step_done, step_count, {5'd0, 5'd0, 5'd1}); n_err++;
        end
        step = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_basic_step();
        test_double_step();
        test_wrap_carry();
        test_priority_load();
        test_inc();
        test_load_invalid();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rotor_stack_stepper.md
ROTOR_STACK_STEPPER -- requirements
Module: rotor_stack_stepper

Interface
REQ-001 SHALL have parameter NUM_ROTORS, default 3, number of rotors (2..8); index 0 is the fastest rotor.
REQ-002 SHALL have parameter ALPHA, default 26, alphabet size (2..32); positions are 0..ALPHA-1.
REQ-003 SHALL have parameter PW, default 5, position width in bits (2^PW >= ALPHA).
REQ-004 SHALL have parameter DOUBLE_STEP, default 1, which enables the middle-rotor double-step anomaly.
REQ-005 SHALL have port clock, input, 1, rising-edge clock.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have port step, input, 1, level from keypress; each rising edge requests one stack step.
REQ-008 SHALL have port load, input, 1, single-cycle pulse loading start positions.
REQ-009 SHALL have port start_pos, input, NUM_ROTORS*PW, packed start positions, rotor i at [i*PW +: PW].
REQ-010 SHALL have port notch_pos, input, NUM_ROTORS*PW, packed per-rotor notch (turnover) positions, sampled live.
REQ-011 SHALL have port inc, input, NUM_ROTORS, per-rotor manual single-increment pulses with no carry.
REQ-012 SHALL have port pos, output, NUM_ROTORS*PW, registered current rotor positions.
REQ-013 SHALL have port step_done, output, 1, one-cycle pulse in the cycle the positions reflect a completed step.
REQ-014 SHALL have port carry_out, output, 1, one-cycle pulse when the slowest rotor stepped off its notch.
REQ-015 SHALL have port step_count, output, 16, number of steps since the last reset or load.

Function
REQ-016 SHALL register step into step_q every cycle, including during load and manual increment; step_edge = step & ~step_q.
REQ-017 SHALL, on a cycle with step_edge, update pos on that clock edge, so new values are visible the next cycle (latency 1).
REQ-018 SHALL, on a step, always advance rotor 0.
REQ-019 SHALL, on a step, advance rotor i (i>=1) if rotor i-1's pre-step position equals notch i-1.
REQ-020 SHALL, when DOUBLE_STEP=1, also advance rotor i for 1<=i<=NUM_ROTORS-2 if its own pre-step position equals notch i.
REQ-021 SHALL evaluate all notch conditions on pre-step values only; each rotor advances at most 1 per step.
REQ-022 SHALL wrap every advance from ALPHA-1 to 0; positions never reach values >= ALPHA via stepping.
REQ-023 SHALL, on load, set rotor i to start_pos[i] if start_pos[i] < ALPHA, else 0, clear step_count, and emit no step_done.
REQ-024 SHALL, on an inc[i] pulse, advance only rotor i by 1 with wrap, with no notch propagation, no step_done and no step_count change; multiple inc bits act independently in the same cycle.
REQ-025 SHALL apply priority reset > load > step_edge > inc; a lower-priority event in the same cycle is discarded, not deferred.
REQ-026 SHALL assert step_done exactly one cycle after each accepted step_edge.
REQ-027 SHALL increment step_count by 1 on each accepted step, wrapping from 0xFFFF to 0.
REQ-028 SHALL pulse carry_out together with step_done when rotor NUM_ROTORS-1 advanced from its notch position.
REQ-029 SHALL never match a notch_pos value >= ALPHA, so that rotor never causes a carry.
REQ-030 SHALL treat step held high as a single request; a new request requires step to go low for at least one cycle.

Reset
REQ-031 SHALL, while reset is high, set all pos to 0, clear step_q, step_done, carry_out and step_count.
REQ-032 SHALL abort any pending step when reset arrives, including a step_edge in the same cycle as reset.
REQ-033 SHALL ignore a step held high through reset release until it falls and rises again.

Verification
REQ-034 Basic step: ALPHA=26, load pos{2,1,0}={0,0,24}, notch rotor0=25; step edge -> after 1 cycle pos0=25, step_done=1; second step -> pos0=0, pos1=1.
REQ-035 Double-step: notches r0=16, r1=4; pos{r2,r1,r0}={0,3,16}; step -> {0,4,17}; step -> {1,5,18}.
REQ-036 Wrap and carry: pos={25,25,25}, all notches 25, DOUBLE_STEP=0; step -> {0,0,0}, carry_out=1, step_count+1.
REQ-037 Priority: load and step rising edge in the same cycle -> pos=start_pos, step_count=0, step_done=0; step held high afterwards -> no step.
REQ-038 Manual increment: inc=3'b010 with pos1=25 -> pos1=0, rotor2 unchanged, step_done=0; start_pos value 30 on load -> that rotor=0.
REQ-039 Reset mid-operation: step edge in the same cycle as reset -> all pos=0, step_done never pulses, step_count=0.
